// File: rtl/mem_wb_stage.sv
// MEM stage with MEM/WB pipeline register: 64-bit little-endian load/store to a
// byte-addressed wrapping data memory, branch resolution and store-data forwarding.
module mem_wb_stage #(
    parameter int MEM_BYTES = 1024,
    parameter int ADDR_W    = $clog2(MEM_BYTES)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_to_reg,
    input  logic        reg_write_en,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        branch,
    input  logic        z_flag,
    input  logic [63:0] pc_next,
    input  logic [63:0] alu_out,
    input  logic [63:0] data,
    input  logic [4:0]  rs2,
    input  logic [4:0]  rd,
    output logic        pc_src,
    output logic [63:0] branch_target,
    output logic        mem_to_reg_out,
    output logic        reg_write_en_out,
    output logic [63:0] read_data_out,
    output logic [63:0] alu_out_out,
    output logic [4:0]  rd_out,
    output logic [63:0] wb_value
);

    logic [7:0]        mem_q [MEM_BYTES];
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] byte_idx [8];
    logic [63:0]       load_data;
    logic [63:0]       store_data;
    logic              fwd;

    logic        mem_to_reg_q, mem_to_reg_d;
    logic        reg_write_en_q, reg_write_en_d;
    logic [63:0] read_data_q, read_data_d;
    logic [63:0] alu_out_q, alu_out_d;
    logic [4:0]  rd_q, rd_d;

    // Each of the 8 byte lanes wraps independently modulo the memory size.
    always_comb begin
        addr      = alu_out[ADDR_W-1:0];
        load_data = '0;
        for (int i = 0; i < 8; i++) begin
            byte_idx[i]         = addr + ADDR_W'(i);
            load_data[8*i +: 8] = mem_q[byte_idx[i]];
        end
    end

    assign fwd        = reg_write_en_q && (rd_q != 5'd0) && (rd_q == rs2);
    assign store_data = fwd ? wb_value : data;

    // Reset leaves memory contents alone but blocks any write while asserted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
        end else if (mem_write) begin
            for (int i = 0; i < 8; i++) begin
                mem_q[byte_idx[i]] <= store_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        mem_to_reg_d   = mem_to_reg;
        reg_write_en_d = reg_write_en;
        read_data_d    = mem_read ? load_data : 64'd0;
        alu_out_d      = alu_out;
        rd_d           = rd;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_to_reg_q   <= 1'b0;
            reg_write_en_q <= 1'b0;
            read_data_q    <= 64'd0;
            alu_out_q      <= 64'd0;
            rd_q           <= 5'd0;
        end else begin
            mem_to_reg_q   <= mem_to_reg_d;
            reg_write_en_q <= reg_write_en_d;
            read_data_q    <= read_data_d;
            alu_out_q      <= alu_out_d;
            rd_q           <= rd_d;
        end
    end

    assign pc_src           = branch & z_flag;
    assign branch_target    = pc_next;
    assign mem_to_reg_out   = mem_to_reg_q;
    assign reg_write_en_out = reg_write_en_q;
    assign read_data_out    = read_data_q;
    assign alu_out_out      = alu_out_q;
    assign rd_out           = rd_q;
    assign wb_value         = mem_to_reg_q ? read_data_q : alu_out_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed scenarios plus random traffic checked against a
// byte-array reference model of memory and the writeback register.
module tb_mem_wb_stage;
  localparam int MB = 1024;

  logic        clk, reset;
  logic        mem_to_reg, reg_write_en, mem_read, mem_write, branch, z_flag;
  logic [63:0] pc_next, alu_out, data;
  logic [4:0]  rs2, rd;
  logic        pc_src, mem_to_reg_out, reg_write_en_out;
  logic [63:0] branch_target, read_data_out, alu_out_out, wb_value;
  logic [4:0]  rd_out;

  mem_wb_stage #(.MEM_BYTES(MB)) dut (
    .clk(clk), .reset(reset),
    .mem_to_reg(mem_to_reg), .reg_write_en(reg_write_en),
    .mem_read(mem_read), .mem_write(mem_write),
    .branch(branch), .z_flag(z_flag),
    .pc_next(pc_next), .alu_out(alu_out), .data(data),
    .rs2(rs2), .rd(rd),
    .pc_src(pc_src), .branch_target(branch_target),
    .mem_to_reg_out(mem_to_reg_out), .reg_write_en_out(reg_write_en_out),
    .read_data_out(read_data_out), .alu_out_out(alu_out_out),
    .rd_out(rd_out), .wb_value(wb_value)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // reference model state
  logic [7:0]  m_mem [MB];
  logic        m_mtr, m_rwe;
  logic [4:0]  m_rd;
  logic [63:0] m_rdata, m_alu;

  logic [63:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [63:0] m_wb();
    return m_mtr ? m_rdata : m_alu;
  endfunction

  function automatic logic [63:0] m_read8(input logic [63:0] a);
    logic [63:0] v = 64'd0;
    for (int b = 0; b < 8; b++) v[8*b +: 8] = m_mem[(int'(a % MB) + b) % MB];
    return v;
  endfunction

  task automatic model_reset();
    m_mtr = 0; m_rwe = 0; m_rd = 0; m_rdata = 0; m_alu = 0;
  endtask

  // driver: called at a negedge, applies one instruction across one posedge
  task automatic step(input logic mr, input logic mw, input logic mtr, input logic rwe,
                      input logic br, input logic z, input logic [63:0] pcn,
                      input logic [63:0] a, input logic [63:0] d,
                      input logic [4:0] r2, input logic [4:0] rdi);
    logic [63:0] sd, ld;
    mem_read = mr; mem_write = mw; mem_to_reg = mtr; reg_write_en = rwe;
    branch = br; z_flag = z; pc_next = pcn; alu_out = a; data = d; rs2 = r2; rd = rdi;
    #1;
    check("pc_src", 64'(pc_src), 64'(br & z));
    check("branch_target", branch_target, pcn);
    sd = (m_rwe && m_rd != 0 && m_rd == r2) ? m_wb() : d;
    ld = mr ? m_read8(a) : 64'd0;
    if (mw) for (int b = 0; b < 8; b++) m_mem[(int'(a % MB) + b) % MB] = sd[8*b +: 8];
    m_mtr = mtr; m_rwe = rwe; m_rd = rdi; m_rdata = ld; m_alu = a;
    exp_q.push_back(ld);
    exp_q.push_back(m_wb());
    @(posedge clk);
    #1;
    check("read_data_out", read_data_out, exp_q.pop_front());
    check("wb_value", wb_value, exp_q.pop_front());
    check("alu_out_out", alu_out_out, m_alu);
    check("rd_out", 64'(rd_out), 64'(m_rd));
    check("mem_to_reg_out", 64'(mem_to_reg_out), 64'(m_mtr));
    check("reg_write_en_out", 64'(reg_write_en_out), 64'(m_rwe));
    @(negedge clk);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rdata"}, read_data_out, 64'd0);
    check({tag, "_alu"}, alu_out_out, 64'd0);
    check({tag, "_rd"}, 64'(rd_out), 64'd0);
    check({tag, "_mtr"}, 64'(mem_to_reg_out), 64'd0);
    check({tag, "_rwe"}, 64'(reg_write_en_out), 64'd0);
    check({tag, "_wb"}, wb_value, 64'd0);
  endtask

  initial begin
    logic [63:0] a;
    for (int i = 0; i < MB; i++) m_mem[i] = 8'd0;
    model_reset();
    reset = 0; mem_read = 0; mem_write = 0; mem_to_reg = 0; reg_write_en = 0;
    branch = 0; z_flag = 0; pc_next = 0; alu_out = 0; data = 0; rs2 = 0; rd = 0;
    #1 reset = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    reset = 0;

    // bring memory to a known all-zero state
    for (int i = 0; i < MB / 8; i++) step(0, 1, 0, 0, 0, 0, 0, 64'(i * 8), 0, 0, 0);

    // aligned store then load
    step(0, 1, 0, 0, 0, 0, 0, 64'd8, 64'h1122334455667788, 0, 0);
    step(1, 0, 1, 1, 0, 0, 0, 64'd8, 0, 0, 5'd3);
    check("t1_load", read_data_out, 64'h1122334455667788);
    check("t1_wb", wb_value, 64'h1122334455667788);

    // wrapping store/load, upper address bits ignored
    step(0, 1, 0, 0, 0, 0, 0, 64'hFFFF_0000_0000_0000 | 64'(MB - 4), 64'hA1A2A3A4A5A6A7A8, 0, 0);
    step(1, 0, 1, 0, 0, 0, 0, 64'(MB - 4), 0, 0, 0);
    check("t2_wrap", read_data_out, 64'hA1A2A3A4A5A6A7A8);
    step(1, 0, 1, 0, 0, 0, 0, 64'd0, 0, 0, 0);
    check("t2_low", 64'(read_data_out[31:0]), 64'hA1A2A3A4);

    // store-data forwarding from writeback, and none for x0
    step(0, 1, 0, 0, 0, 0, 0, 64'd24, 64'hDEAD, 0, 0);
    step(1, 0, 1, 1, 0, 0, 0, 64'd24, 0, 0, 5'd5);
    step(0, 1, 0, 0, 0, 0, 0, 64'd16, 64'd0, 5'd5, 0);
    step(1, 0, 1, 0, 0, 0, 0, 64'd16, 0, 0, 0);
    check("t3_fwd", read_data_out, 64'hDEAD);
    step(1, 0, 1, 1, 0, 0, 0, 64'd24, 0, 0, 5'd0);
    step(0, 1, 0, 0, 0, 0, 0, 64'd16, 64'h77, 5'd0, 0);
    step(1, 0, 1, 0, 0, 0, 0, 64'd16, 0, 0, 0);
    check("t3_nofwd_x0", read_data_out, 64'h77);

    // branch resolution
    step(0, 0, 0, 0, 1, 1, 64'h40, 64'd0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 64'h40, 64'd0, 0, 0, 0);

    // no load: read data is zero, writeback takes the ALU result
    step(0, 0, 0, 1, 0, 0, 0, 64'h55, 0, 0, 5'd9);
    check("t6_rdata", read_data_out, 64'd0);
    check("t6_wb", wb_value, 64'h55);

    // simultaneous read and write: pre-write data returned
    step(1, 1, 1, 0, 0, 0, 0, 64'd8, 64'hCAFEF00D, 0, 0);
    check("rw_pre", read_data_out, 64'h1122334455667788);

    // asynchronous reset mid-stream with a store pending at the reset edge
    step(1, 0, 1, 1, 0, 0, 0, 64'd8, 0, 0, 5'd7);
    mem_write = 1; alu_out = 64'd8; data = 64'h0BAD0BAD; rs2 = 0; mem_read = 0;
    #2 reset = 1;
    #1 check_outputs_zero("async_reset");
    @(posedge clk);
    #1;
    @(negedge clk);
    reset = 0;
    model_reset();
    step(1, 0, 1, 0, 0, 0, 0, 64'd8, 0, 0, 0);
    check("reset_mem_kept", read_data_out, 64'hCAFEF00D);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      logic mr, mw;
      a = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) a[9:0] = 10'($urandom_range(MB - 12, MB - 1));
      else a[9:0] = 10'($urandom_range(0, 40));
      mr = ($urandom_range(0, 2) == 0);
      mw = ($urandom_range(0, 2) == 0);
      if (mr && mw && $urandom_range(0, 7) != 0) mw = 0;
      step(mr, mw, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           {$urandom, $urandom}, a, {$urandom, $urandom},
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no_finish expected finish");
    $fatal(1);
  end
endmodule
